// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy states and default per-boundary widths.
package pipe_pkg;

  localparam int unsigned MEMWB_DATA_W = 69;  // ALU result + read data + write register
  localparam int unsigned MEMWB_CTRL_W = 2;   // RegWrite, MemtoReg
  localparam int unsigned EXMEM_CTRL_W = 5;   // WB bits plus Branch/MemRead/MemWrite

  // Encoding is {skid_v, out_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } pipe_state_e;

  function automatic logic state_out_valid(input pipe_state_e s);
    return s[0];
  endfunction

  function automatic logic state_skid_valid(input pipe_state_e s);
    return s[1];
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// Single holding register for one stage entry; clear wins over load.
module pipe_skid_slot #(
  parameter int unsigned W = 71
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] slot_q;
  logic [W-1:0] slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clear) begin
      slot_d = '0;
    end else if (load) begin
      slot_d = d;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q = slot_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with a one-entry skid slot, flush,
// bubble insertion and a saturating bubble counter. State updates on negedge clk.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = MEMWB_DATA_W,
  parameter int unsigned CTRL_W = MEMWB_CTRL_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic              acc;
  logic              drn;
  logic              out_valid_w;
  logic              skid_load;
  logic              skid_clear;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign out_valid_w = state_out_valid(state_q);
  assign acc         = in_valid & in_ready_q;
  assign drn         = out_valid_w & out_ready;

  pipe_skid_slot #(
    .W (DATA_W + CTRL_W)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     ({in_ctrl, in_data}),
    .q     ({skid_ctrl, skid_data})
  );

  // Every transition into a bubble also zeroes the control field, so no
  // RegWrite/MemtoReg side effect can leak out while out_valid is low.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ctrl_d = out_ctrl_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      state_d    = ST_EMPTY;
      out_ctrl_d = '0;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d    = ST_ONE;
            out_data_d = in_data;
            out_ctrl_d = in_ctrl;
          end
        end
        ST_ONE: begin
          if (acc && drn) begin
            out_data_d = in_data;
            out_ctrl_d = in_ctrl;
          end else if (acc) begin
            state_d   = ST_TWO;
            skid_load = 1'b1;
          end else if (drn) begin
            state_d    = ST_EMPTY;
            out_ctrl_d = '0;
          end
        end
        ST_TWO: begin
          if (drn) begin
            state_d    = ST_ONE;
            out_data_d = skid_data;
            out_ctrl_d = skid_ctrl;
            skid_clear = 1'b1;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          out_ctrl_d = '0;
          skid_clear = 1'b1;
        end
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!out_valid_w && out_ready && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_EMPTY;
      out_data_q   <= '0;
      out_ctrl_q   <= '0;
      in_ready_q   <= 1'b1;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_ctrl_q   <= out_ctrl_d;
      in_ready_q   <= in_ready_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_w;
  assign out_data   = out_data_q;
  assign out_ctrl   = out_ctrl_q;
  assign bubble_cnt = bubble_cnt_q;

  a_state_legal : assert property (@(negedge clk) disable iff (!rst)
    (state_q inside {ST_EMPTY, ST_ONE, ST_TWO}));

  a_ready_tracks_state : assert property (@(negedge clk) disable iff (!rst)
    (in_ready_q == !state_skid_valid(state_q)));

  a_bubble_ctrl_zero : assert property (@(negedge clk) disable iff (!rst)
    (!out_valid_w |-> (out_ctrl_q == '0)));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg against a two-deep FIFO reference model.
module tb_pipe_stage_reg;

  localparam int DW = 69;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          in_ready,  in_ready_s;
  logic          out_valid, out_valid_s;
  logic [DW-1:0] out_data,  out_data_s;
  logic [CW-1:0] out_ctrl,  out_ctrl_s;
  logic [15:0]   bubble_cnt;
  logic [2:0]    bubble_cnt_s;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_ctrl(out_ctrl_s),
    .bubble_cnt(bubble_cnt_s)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t        exp_q[$];
  int unsigned idle_edges;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a stage holds at most two entries in arrival order.
  always @(negedge clk or negedge rst) begin
    bit   acc, drn;
    ent_t e;
    if (!rst) begin
      exp_q.delete();
      idle_edges = 0;
    end else begin
      acc = in_valid && (exp_q.size() < 2);
      drn = (exp_q.size() > 0) && out_ready;
      if ((exp_q.size() == 0) && out_ready) idle_edges++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (drn) void'(exp_q.pop_front());
        if (acc) begin
          e.d = in_data;
          e.c = in_ctrl;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: compare what the DUT presents against the model head.
  always @(posedge clk) begin
    int unsigned   n;
    logic [15:0]   exp16;
    logic [2:0]    exp3;
    logic [CW-1:0] ectrl;
    n     = exp_q.size();
    exp16 = (idle_edges > 65535) ? 16'hFFFF : idle_edges[15:0];
    exp3  = (idle_edges > 7) ? 3'd7 : idle_edges[2:0];
    ectrl = (n > 0) ? exp_q[0].c : '0;
    check("out_valid",     DW'(out_valid),    DW'(n > 0));
    check("in_ready",      DW'(in_ready),     DW'(n < 2));
    check("out_ctrl",      DW'(out_ctrl),     DW'(ectrl));
    check("bubble_cnt",    DW'(bubble_cnt),   DW'(exp16));
    check("out_valid_w3",  DW'(out_valid_s),  DW'(n > 0));
    check("in_ready_w3",   DW'(in_ready_s),   DW'(n < 2));
    check("out_ctrl_w3",   DW'(out_ctrl_s),   DW'(ectrl));
    check("bubble_cnt_w3", DW'(bubble_cnt_s), DW'(exp3));
    if (n > 0) begin
      check("out_data",    out_data,   exp_q[0].d);
      check("out_data_w3", out_data_s, exp_q[0].d);
    end
  end

  task automatic drive(input logic v, input logic r, input logic f,
                       input logic [DW-1:0] d, input logic [CW-1:0] c);
    @(posedge clk);
    #1;
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_data   = d;
    in_ctrl   = c;
  endtask

  task automatic after_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset mid-stream, taking effect between clock edges
    drive(0, 1, 0, '0, '0);
    drive(0, 1, 0, '0, '0);
    drive(1, 0, 0, DW'(32'hDEADBEEF), 2'b11);
    after_edge();
    check("pre_reset_valid", DW'(out_valid), DW'(1));
    check("pre_reset_ctrl",  DW'(out_ctrl),  DW'(2'b11));
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid",  DW'(out_valid),  DW'(0));
    check("rst_out_ctrl",   DW'(out_ctrl),   DW'(0));
    check("rst_out_data",   out_data,        '0);
    check("rst_bubble_cnt", DW'(bubble_cnt), DW'(0));
    check("rst_in_ready",   DW'(in_ready),   DW'(1));
    in_valid = 1'b0;
    drive(0, 0, 0, '0, '0);
    rst = 1'b1;

    // Streaming, one entry per edge
    for (int k = 0; k < 8; k++) drive(1, 1, 0, DW'(k), 2'b01);
    after_edge();
    check("stream_last", out_data, DW'(7));
    drive(0, 1, 0, '0, '0);
    drive(0, 1, 0, '0, '0);

    // Stall fills the skid slot; C waits until back-pressure releases
    drive(1, 0, 0, DW'(69'hA), 2'b10);
    drive(1, 0, 0, DW'(69'hB), 2'b01);
    after_edge();
    check("skid_in_ready", DW'(in_ready), DW'(0));
    for (int i = 0; i < 3; i++) drive(1, 0, 0, DW'(69'hC), 2'b11);
    after_edge();
    check("skid_hold_data", out_data, DW'(69'hA));
    drive(1, 1, 0, DW'(69'hC), 2'b11);
    after_edge();
    check("skid_b_out", out_data, DW'(69'hB));
    drive(1, 1, 0, DW'(69'hC), 2'b11);
    after_edge();
    check("skid_c_out", out_data, DW'(69'hC));
    drive(0, 1, 0, '0, '0);

    // Flush while full, with a simultaneous incoming entry
    drive(1, 0, 0, DW'(69'h11), 2'b11);
    drive(1, 0, 0, DW'(69'h22), 2'b11);
    drive(1, 0, 1, DW'(69'h33), 2'b11);
    after_edge();
    check("flush_valid",    DW'(out_valid), DW'(0));
    check("flush_ctrl",     DW'(out_ctrl),  DW'(0));
    check("flush_in_ready", DW'(in_ready),  DW'(1));
    drive(0, 0, 0, '0, '0);

    // Bubble counting and saturation of the narrow counter
    do_reset();
    for (int i = 0; i < 5; i++) drive(0, 1, 0, '0, '0);
    after_edge();
    check("bubble_5",    DW'(bubble_cnt),   DW'(5));
    check("bubble_ctrl", DW'(out_ctrl),     DW'(0));
    for (int i = 0; i < 5; i++) drive(0, 1, 0, '0, '0);
    after_edge();
    check("bubble_10",   DW'(bubble_cnt),   DW'(10));
    check("bubble_sat7", DW'(bubble_cnt_s), DW'(7));

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      drive(logic'($urandom_range(0, 99) < 60),
            logic'($urandom_range(0, 99) < 65),
            logic'($urandom_range(0, 99) < 3),
            {$urandom, $urandom, 5'($urandom)},
            2'($urandom));
    end
    for (int i = 0; i < 4; i++) drive(0, 1, 0, '0, '0);
    after_edge();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
